lpc_reg_ctrl: RTL and testbench

Register-window controller sitting beside the LPC peripheral FSM. It decodes the peripheral's captured address into `addr_hit_o` and supplies read data on `din_o`. It commits host write data into a small byte register file. It also arbitrates that register file between the LPC side and a local fabric port, with LPC always taking priority because its bus timing cannot be stretched.

---
 rtl/lpc_reg_ctrl_if.sv | 36 +++
 rtl/lpc_reg_ctrl.sv | 89 ++++++++
 tb/tb_lpc_reg_ctrl.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/lpc_reg_ctrl_if.sv
// Bus bundle between the LPC peripheral / local fabric and the register-window controller.
// The controller takes the slave view; the peripheral and fabric side take the master view.
interface lpc_reg_ctrl_if #(
    parameter int ADDR_W = 3
);
    logic [15:0]       lpc_addr_i;
    logic [7:0]        lpc_data_in_i;
    logic              io_rden_i;
    logic              io_wren_i;
    logic              addr_hit_o;
    logic [7:0]        din_o;
    logic              loc_req_i;
    logic              loc_we_i;
    logic [ADDR_W-1:0] loc_addr_i;
    logic [7:0]        loc_wdata_i;
    logic              loc_gnt_o;
    logic [7:0]        loc_rdata_o;
    logic              loc_valid_o;
    logic              wr_evt_o;
    logic [ADDR_W-1:0] wr_idx_o;
    logic              busy_o;

    modport slave (
        input  lpc_addr_i, lpc_data_in_i, io_rden_i, io_wren_i,
        input  loc_req_i, loc_we_i, loc_addr_i, loc_wdata_i,
        output addr_hit_o, din_o, loc_gnt_o, loc_rdata_o, loc_valid_o,
        output wr_evt_o, wr_idx_o, busy_o
    );

    modport master (
        output lpc_addr_i, lpc_data_in_i, io_rden_i, io_wren_i,
        output loc_req_i, loc_we_i, loc_addr_i, loc_wdata_i,
        input  addr_hit_o, din_o, loc_gnt_o, loc_rdata_o, loc_valid_o,
        input  wr_evt_o, wr_idx_o, busy_o
    );
endinterface

// File: rtl/lpc_reg_ctrl.sv
// LPC register window: address decode, read data, write commit into a byte register file,
// and arbitration of that file against a local fabric port (LPC always wins).
module lpc_reg_ctrl #(
    parameter logic [15:0]            BASE_ADDR   = 16'h0080,
    parameter int                     ADDR_W      = 3,
    parameter logic [(1<<ADDR_W)-1:0] LPC_WR_MASK = 'hFE
) (
    input  logic          clk_i,
    input  logic          nrst_i,
    lpc_reg_ctrl_if.slave bus
);
    localparam int NREG = 1 << ADDR_W;
    localparam logic [15-ADDR_W:0] BASE_TAG = BASE_ADDR[15:ADDR_W];

    typedef enum logic [1:0] {IDLE, LPC_RD, LPC_WR} state_t;

    state_t            state;
    logic [7:0]        regs [NREG];
    logic              rden_q, wren_q;
    logic [7:0]        din_q, loc_rdata_q;
    logic              loc_valid_q, wr_evt_q;
    logic [ADDR_W-1:0] wr_idx_q;

    logic              hit, rd_rise, wr_rise, loc_gnt;
    logic [ADDR_W-1:0] idx;

    assign hit     = (bus.lpc_addr_i[15:ADDR_W] == BASE_TAG);
    assign idx     = bus.lpc_addr_i[ADDR_W-1:0];
    assign rd_rise = bus.io_rden_i & ~rden_q;
    assign wr_rise = bus.io_wren_i & ~wren_q;

    // NOTE: the grant is combinational so a request in IDLE executes in the same cycle; any
    // active LPC enable blocks it, which also keeps din_o stable across the DATA phase.
    assign loc_gnt = (state == IDLE) & bus.loc_req_i & ~bus.io_rden_i & ~bus.io_wren_i;

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            state       <= IDLE;
            rden_q      <= 1'b0;
            wren_q      <= 1'b0;
            din_q       <= '0;
            loc_rdata_q <= '0;
            loc_valid_q <= 1'b0;
            wr_evt_q    <= 1'b0;
            wr_idx_q    <= '0;
            // NOTE: the register file is a handful of flops with a defined reset value, not a
            // RAM, so clearing every entry here is intended.
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            rden_q      <= bus.io_rden_i;
            wren_q      <= bus.io_wren_i;
            loc_valid_q <= 1'b0;
            wr_evt_q    <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (rd_rise && hit) begin
                        din_q <= regs[idx];
                        state <= LPC_RD;
                    end else if (wr_rise && hit) begin
                        if (LPC_WR_MASK[idx]) regs[idx] <= bus.lpc_data_in_i;
                        wr_evt_q <= 1'b1;
                        wr_idx_q <= idx;
                        state    <= LPC_WR;
                    end else if (loc_gnt) begin
                        if (bus.loc_we_i) begin
                            regs[bus.loc_addr_i] <= bus.loc_wdata_i;
                        end else begin
                            loc_rdata_q <= regs[bus.loc_addr_i];
                            loc_valid_q <= 1'b1;
                        end
                    end
                end
                LPC_RD, LPC_WR: begin
                    if (!bus.io_rden_i && !bus.io_wren_i) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.addr_hit_o  = hit;
    assign bus.din_o       = din_q;
    assign bus.loc_gnt_o   = loc_gnt;
    assign bus.loc_rdata_o = loc_rdata_q;
    assign bus.loc_valid_o = loc_valid_q;
    assign bus.wr_evt_o    = wr_evt_q;
    assign bus.wr_idx_o    = wr_idx_q;
    assign bus.busy_o      = (state != IDLE);
endmodule

// File: tb/tb_lpc_reg_ctrl.sv
// Directed bench for lpc_reg_ctrl: a scoreboard queue holds the expected pulse responses
// (local read data, LPC write events) and a monitor matches them as the DUT presents them.
module tb_lpc_reg_ctrl;
    localparam int ADDR_W = 3;

    typedef enum logic {EXP_RDATA, EXP_WEVT} exp_kind_t;
    typedef struct packed {
        exp_kind_t  kind;
        logic [7:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    exp_t exp_q[$];

    lpc_reg_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    lpc_reg_ctrl #(
        .BASE_ADDR  (16'h0080),
        .ADDR_W     (ADDR_W),
        .LPC_WR_MASK(8'hFE)
    ) dut (
        .clk_i (clk),
        .nrst_i(nrst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks run after a further settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every output pulse must match the head of the expected queue.
    initial begin
        forever begin
            @(negedge clk);
            if (nrst && bus.loc_valid_o) begin
                if (exp_q.size() == 0 || exp_q[0].kind != EXP_RDATA) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_loc_valid: got rdata %0h, none expected", bus.loc_rdata_o);
                end else begin
                    check("loc_rdata", {8'h0, bus.loc_rdata_o}, {8'h0, exp_q[0].val});
                    void'(exp_q.pop_front());
                end
            end
            if (nrst && bus.wr_evt_o) begin
                if (exp_q.size() == 0 || exp_q[0].kind != EXP_WEVT) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_wr_evt: got idx %0d, none expected", bus.wr_idx_o);
                end else begin
                    check("wr_idx", {13'h0, bus.wr_idx_o}, {8'h0, exp_q[0].val});
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic loc_write(input logic [ADDR_W-1:0] a, input logic [7:0] d);
        tick();
        bus.loc_req_i = 1'b1; bus.loc_we_i = 1'b1; bus.loc_addr_i = a; bus.loc_wdata_i = d;
        #1 check("loc_gnt_write", {15'h0, bus.loc_gnt_o}, 16'h1);
        tick();
        bus.loc_req_i = 1'b0;
    endtask

    task automatic loc_read(input logic [ADDR_W-1:0] a, input logic [7:0] exp);
        tick();
        bus.loc_req_i = 1'b1; bus.loc_we_i = 1'b0; bus.loc_addr_i = a;
        exp_q.push_back('{EXP_RDATA, exp});
        #1 check("loc_gnt_read", {15'h0, bus.loc_gnt_o}, 16'h1);
        tick();
        bus.loc_req_i = 1'b0;
    endtask

    // Two-clock LPC write to an in-window address; the event pulse is always expected.
    task automatic lpc_write(input logic [15:0] a, input logic [7:0] d, input logic [7:0] exp_idx);
        tick();
        bus.lpc_addr_i = a; bus.lpc_data_in_i = d; bus.io_wren_i = 1'b1;
        exp_q.push_back('{EXP_WEVT, exp_idx});
        #1 check("wr_hit", {15'h0, bus.addr_hit_o}, 16'h1);
        tick();
        #1 check("wr_busy", {15'h0, bus.busy_o}, 16'h1);
        check("wr_idx_direct", {13'h0, bus.wr_idx_o}, {8'h0, exp_idx});
        tick();
        bus.io_wren_i = 1'b0;
        tick();
        #1 check("wr_idle", {15'h0, bus.busy_o}, 16'h0);
    endtask

    initial begin
        bus.lpc_addr_i = '0; bus.lpc_data_in_i = '0; bus.io_rden_i = 1'b0; bus.io_wren_i = 1'b0;
        bus.loc_req_i = 1'b0; bus.loc_we_i = 1'b0; bus.loc_addr_i = '0; bus.loc_wdata_i = '0;
        repeat (3) @(posedge clk);
        #1 check("rst_din", {8'h0, bus.din_o}, 16'h0);
        check("rst_busy", {15'h0, bus.busy_o}, 16'h0);
        check("rst_wr_idx", {13'h0, bus.wr_idx_o}, 16'h0);
        check("rst_loc_rdata", {8'h0, bus.loc_rdata_o}, 16'h0);
        nrst = 1'b1;

        // Window boundaries.
        bus.lpc_addr_i = 16'h007F; #1 check("hit_007F", {15'h0, bus.addr_hit_o}, 16'h0);
        bus.lpc_addr_i = 16'h0080; #1 check("hit_0080", {15'h0, bus.addr_hit_o}, 16'h1);
        bus.lpc_addr_i = 16'h0087; #1 check("hit_0087", {15'h0, bus.addr_hit_o}, 16'h1);
        bus.lpc_addr_i = 16'h0088; #1 check("hit_0088", {15'h0, bus.addr_hit_o}, 16'h0);
        bus.lpc_addr_i = 16'h1080; #1 check("hit_1080", {15'h0, bus.addr_hit_o}, 16'h0);

        // Local write reg3, then LPC read at 0x0083.
        loc_write(3'd3, 8'hA5);
        tick();
        bus.lpc_addr_i = 16'h0083; bus.io_rden_i = 1'b1;
        #1 check("rd_hit", {15'h0, bus.addr_hit_o}, 16'h1);
        tick();
        #1 check("rd_din", {8'h0, bus.din_o}, 16'h00A5);
        check("rd_busy1", {15'h0, bus.busy_o}, 16'h1);
        tick();
        #1 check("rd_busy2", {15'h0, bus.busy_o}, 16'h1);
        bus.io_rden_i = 1'b0;
        tick();
        #1 check("rd_idle", {15'h0, bus.busy_o}, 16'h0);
        check("rd_din_hold", {8'h0, bus.din_o}, 16'h00A5);

        // LPC write reg5, read back locally; masked write to reg0 leaves it at 0.
        lpc_write(16'h0085, 8'h3C, 8'd5);
        loc_read(3'd5, 8'h3C);
        lpc_write(16'h0080, 8'h77, 8'd0);
        loc_read(3'd0, 8'h00);

        // Local write requested on the same clock as an LPC write rise.
        tick();
        bus.loc_req_i = 1'b1; bus.loc_we_i = 1'b1; bus.loc_addr_i = 3'd6; bus.loc_wdata_i = 8'h11;
        bus.lpc_addr_i = 16'h0086; bus.lpc_data_in_i = 8'h22; bus.io_wren_i = 1'b1;
        exp_q.push_back('{EXP_WEVT, 8'd6});
        #1 check("arb_gnt_rise", {15'h0, bus.loc_gnt_o}, 16'h0);
        tick();
        #1 check("arb_gnt_wr1", {15'h0, bus.loc_gnt_o}, 16'h0);
        tick();
        #1 check("arb_gnt_wr2", {15'h0, bus.loc_gnt_o}, 16'h0);
        bus.io_wren_i = 1'b0;
        #1 check("arb_gnt_drop", {15'h0, bus.loc_gnt_o}, 16'h0);
        tick();
        #1 check("arb_gnt_idle", {15'h0, bus.loc_gnt_o}, 16'h1);
        tick();
        bus.loc_req_i = 1'b0;
        loc_read(3'd6, 8'h11);

        // Out-of-window read with a local read pending.
        tick();
        bus.lpc_addr_i = 16'h0090; bus.io_rden_i = 1'b1;
        bus.loc_req_i = 1'b1; bus.loc_we_i = 1'b0; bus.loc_addr_i = 3'd3;
        #1 check("miss_hit", {15'h0, bus.addr_hit_o}, 16'h0);
        check("miss_gnt0", {15'h0, bus.loc_gnt_o}, 16'h0);
        tick();
        #1 check("miss_din", {8'h0, bus.din_o}, 16'h00A5);
        check("miss_busy", {15'h0, bus.busy_o}, 16'h0);
        check("miss_gnt1", {15'h0, bus.loc_gnt_o}, 16'h0);
        tick();
        #1 check("miss_gnt2", {15'h0, bus.loc_gnt_o}, 16'h0);
        bus.io_rden_i = 1'b0;
        exp_q.push_back('{EXP_RDATA, 8'hA5});
        #1 check("miss_gnt_after", {15'h0, bus.loc_gnt_o}, 16'h1);
        tick();
        bus.loc_req_i = 1'b0;

        // Read and write rising together: the read wins, reg4 is not written.
        tick();
        bus.lpc_addr_i = 16'h0084; bus.lpc_data_in_i = 8'h99;
        bus.io_rden_i = 1'b1; bus.io_wren_i = 1'b1;
        tick();
        #1 check("both_din", {8'h0, bus.din_o}, 16'h0000);
        check("both_busy", {15'h0, bus.busy_o}, 16'h1);
        tick();
        bus.io_rden_i = 1'b0; bus.io_wren_i = 1'b0;
        tick();
        loc_read(3'd4, 8'h00);

        // Reset between the write rise and its commit edge.
        tick();
        bus.lpc_addr_i = 16'h0087; bus.lpc_data_in_i = 8'h5A; bus.io_wren_i = 1'b1;
        #1 nrst = 1'b0;
        #1 check("arst_din", {8'h0, bus.din_o}, 16'h0);
        check("arst_busy", {15'h0, bus.busy_o}, 16'h0);
        check("arst_wr_idx", {13'h0, bus.wr_idx_o}, 16'h0);
        check("arst_loc_rdata", {8'h0, bus.loc_rdata_o}, 16'h0);
        check("arst_wr_evt", {15'h0, bus.wr_evt_o}, 16'h0);
        check("arst_loc_valid", {15'h0, bus.loc_valid_o}, 16'h0);
        bus.io_wren_i = 1'b0;
        tick();
        nrst = 1'b1;
        loc_read(3'd7, 8'h00);
        loc_read(3'd3, 8'h00);
        loc_read(3'd5, 8'h00);

        repeat (3) tick();
        check("scoreboard_empty", 16'(exp_q.size()), 16'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
